// File: rtl/serial_adder_controller_pkg.sv
// rtl/serial_adder_controller_pkg.sv - shared state encoding, nibble width and width rule
package serial_adder_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB = 4;

  // Operands are consumed one nibble at a time, so the width must tile exactly.
  function automatic bit width_ok(input int w);
    return (w >= NIB) && ((w % NIB) == 0);
  endfunction

endpackage

// File: rtl/serial_adder_controller_four_bit_adder.sv
// rtl/serial_adder_controller_four_bit_adder.sv - 4-bit ripple adder slice used as the nibble datapath
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);

  logic [4:0] total;

  assign total     = {1'b0, a} + {1'b0, b} + {4'b0000, carry_in};
  assign sum       = total[3:0];
  assign carry_out = total[4];

endmodule

// File: rtl/serial_adder_controller.sv
// rtl/serial_adder_controller.sv - nibble-serial WIDTH-bit adder sequencer; SERIAL_SUB_EN adds subtraction
module serial_adder_controller
  import serial_adder_controller_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIN,
`ifdef SERIAL_SUB_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOUT
);

  localparam int N  = WIDTH / NIB;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (!width_ok(WIDTH)) begin : g_width_check
      $error("serial_adder_controller: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    step;
  logic             carry;
  logic             carry_init;
  logic             last_step;
  logic [NIB-1:0]   nib_b;
  logic [NIB-1:0]   nib_sum;
  logic             nib_cout;

`ifdef SERIAL_SUB_EN
  logic sub_q;

  // Subtraction is A + ~B + 1, so B is inverted per nibble and the chain starts with carry 1.
  assign nib_b      = sub_q ? ~opb[NIB-1:0] : opb[NIB-1:0];
  assign carry_init = Sub ? 1'b1 : CarryIN;
`else
  assign nib_b      = opb[NIB-1:0];
  assign carry_init = CarryIN;
`endif

  assign last_step = (step == CW'(N - 1));

  four_bit_adder u_nibble (
    .a         (opa[NIB-1:0]),
    .b         (nib_b),
    .carry_in  (carry),
    .sum       (nib_sum),
    .carry_out (nib_cout)
  );

  // The newest nibble enters at the MSB end so after N steps the low nibble sits at bit 0.
  generate
    if (WIDTH == NIB) begin : g_acc_single
      assign acc_next = nib_sum;
    end else begin : g_acc_shift
      assign acc_next = {nib_sum, acc[WIDTH-1:NIB]};
    end
  endgenerate

  // State register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: Start is only looked at in IDLE, so requests during RUN/DONE are dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (state)
      RUN:     Busy = 1'b1;
      DONE: begin
        Busy = 1'b1;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand shift registers, carry chain, step index and result registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      step     <= '0;
      carry    <= 1'b0;
      Sum      <= '0;
      CarryOUT <= 1'b0;
`ifdef SERIAL_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            opa   <= A;
            opb   <= B;
            carry <= carry_init;
            step  <= '0;
`ifdef SERIAL_SUB_EN
            sub_q <= Sub;
`endif
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= nib_cout;
          opa   <= opa >> NIB;
          opb   <= opb >> NIB;
          step  <= step + CW'(1);
          if (last_step) begin
            Sum      <= acc_next;
            CarryOUT <= nib_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_controller.sv
// tb/tb_serial_adder_controller.sv - directed self-checking bench for serial_adder_controller
module tb_serial_adder_controller;

  logic        CLK;
  logic        RESETn;
  logic        Start;
  logic [15:0] A;
  logic [15:0] B;
  logic        CarryIN;
`ifdef SERIAL_SUB_EN
  logic        Sub;
`endif
  logic        Busy;
  logic        Done;
  logic [15:0] Sum;
  logic        CarryOUT;

  int tests;
  int fails;

  serial_adder_controller #(.WIDTH(16)) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .Start    (Start),
    .A        (A),
    .B        (B),
    .CarryIN  (CarryIN),
`ifdef SERIAL_SUB_EN
    .Sub      (Sub),
`endif
    .Busy     (Busy),
    .Done     (Done),
    .Sum      (Sum),
    .CarryOUT (CarryOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full operation: accept, expect Done after 4 steps with 5 busy cycles, then idle with held result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [15:0] exp_sum, input logic exp_cout);
    int lat;
    int busy_n;
    bit seen;
    @(negedge CLK);
    A = a;
    B = b;
    CarryIN = cin;
    Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    lat = 0;
    busy_n = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (Busy) busy_n++;
      if (Done) begin
        seen = 1'b1;
      end else begin
        @(negedge CLK);
        lat++;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, lat, 32'd4);
    check({tag, "_busy_cycles_to_done"}, busy_n, 32'd5);
    check({tag, "_sum"}, 32'(Sum), 32'(exp_sum));
    check({tag, "_carry"}, 32'(CarryOUT), 32'(exp_cout));
    @(negedge CLK);
    check({tag, "_busy_after"}, 32'(Busy), 32'd0);
    check({tag, "_done_after"}, 32'(Done), 32'd0);
    check({tag, "_sum_hold"}, 32'(Sum), 32'(exp_sum));
  endtask

  logic [15:0] bb_a    [3];
  logic [15:0] bb_b    [3];
  logic [15:0] bb_sum  [3];
  logic        bb_cout [3];
  int          done_n;

  initial begin
    tests = 0;
    fails = 0;
    RESETn = 1'b0;
    Start = 1'b0;
    A = '0;
    B = '0;
    CarryIN = 1'b0;
`ifdef SERIAL_SUB_EN
    Sub = 1'b0;
`endif
    bb_a[0] = 16'h0102; bb_b[0] = 16'h0304; bb_sum[0] = 16'h0406; bb_cout[0] = 1'b0;
    bb_a[1] = 16'hF000; bb_b[1] = 16'h1000; bb_sum[1] = 16'h0000; bb_cout[1] = 1'b1;
    bb_a[2] = 16'h7FFF; bb_b[2] = 16'h0001; bb_sum[2] = 16'h8000; bb_cout[2] = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_sum", 32'(Sum), 32'd0);
    check("reset_carry", 32'(CarryOUT), 32'd0);
    @(negedge CLK);
    RESETn = 1'b1;

    // Basic add with carry across a nibble boundary
    run_op("add_00ff_0001", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

    // Start during RUN is ignored: one Done, first result unchanged
    @(negedge CLK);
    A = 16'h00FF;
    B = 16'h0001;
    CarryIN = 1'b0;
    Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    done_n = 0;
    for (int c = 0; c < 12; c++) begin
      if (Done) done_n++;
      if (c == 2) begin
        A = 16'h1111;
        B = 16'h1111;
        Start = 1'b1;
      end
      if (c == 3) Start = 1'b0;
      @(negedge CLK);
    end
    check("ignore_done_count", done_n, 32'd1);
    check("ignore_sum", 32'(Sum), 32'h0100);
    check("ignore_carry", 32'(CarryOUT), 32'd0);

    // Reset during the second RUN step abandons the operation
    @(negedge CLK);
    A = 16'hAAAA;
    B = 16'h5555;
    Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    RESETn = 1'b0;
    #1;
    check("midrun_reset_busy", 32'(Busy), 32'd0);
    check("midrun_reset_done", 32'(Done), 32'd0);
    check("midrun_reset_sum", 32'(Sum), 32'd0);
    check("midrun_reset_carry", 32'(CarryOUT), 32'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    done_n = 0;
    for (int c = 0; c < 8; c++) begin
      if (Done || Busy) done_n++;
      @(negedge CLK);
    end
    check("midrun_reset_no_done", done_n, 32'd0);
    run_op("add_after_reset", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);

    // Carry ripples through all four nibbles
    run_op("add_ffff_0000_c1", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    run_op("add_ffff_ffff_c1", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    run_op("add_8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

`ifdef SERIAL_SUB_EN
    // Subtraction: CarryIN ignored, CarryOUT=1 means no borrow
    Sub = 1'b1;
    run_op("sub_5_minus_7", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    run_op("sub_7_minus_5", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1);
    Sub = 1'b0;
`endif

    // Back-to-back with Start held high: accepted every 6 cycles
    @(negedge CLK);
    A = bb_a[0];
    B = bb_b[0];
    CarryIN = 1'b0;
    Start = 1'b1;
    @(posedge CLK);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check($sformatf("b2b%0d_accepted", i), 32'(Busy), 32'd1);
      if (i < 2) begin
        A = bb_a[i + 1];
        B = bb_b[i + 1];
      end else begin
        Start = 1'b0;
      end
      repeat (3) @(negedge CLK);
      check($sformatf("b2b%0d_no_early_done", i), 32'(Done), 32'd0);
      @(negedge CLK);
      check($sformatf("b2b%0d_done", i), 32'(Done), 32'd1);
      check($sformatf("b2b%0d_sum", i), 32'(Sum), 32'(bb_sum[i]));
      check($sformatf("b2b%0d_carry", i), 32'(CarryOUT), 32'(bb_cout[i]));
      @(negedge CLK);
      check($sformatf("b2b%0d_idle_gap", i), 32'(Busy), 32'd0);
      check($sformatf("b2b%0d_sum_hold", i), 32'(Sum), 32'(bb_sum[i]));
      @(posedge CLK);
    end
    @(negedge CLK);
    check("b2b_stop_busy", 32'(Busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder_controller.md
# serial_adder_controller

Multi-precision adder sequencer that reuses a single `four_bit_adder` datapath to add WIDTH-bit operands one nibble per cycle. The carry is chained between nibbles through a carry register. Operands are latched on a start handshake, and a done pulse is raised when the full result is valid. It sits between a requester (test harness or future ALU control) and the 4-bit adder slice, trading latency for area.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4; N = WIDTH/4 nibble steps.
- CLK  in  1  single clock; all state updates on the rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- A  in  WIDTH  operand A; latched when Start is accepted.
- B  in  WIDTH  operand B; latched when Start is accepted.
- CarryIN  in  1  initial carry; latched when Start is accepted.
- Sub  in  1  subtract request; latched when Start is accepted; exists only with SERIAL_SUB_EN.
- Busy  out  1  high in RUN and DONE.
- Done  out  1  one-cycle pulse; Sum and CarryOUT are valid in this cycle.
- Sum  out  WIDTH  registered result.
- CarryOUT  out  1  registered final carry.

## Operation
- Reset (RESETn low): state IDLE; all outputs forced to 0 (Busy, Done, Sum, CarryOUT); step index, carry register and operand shift registers cleared.
- IDLE:
  - Start=1 at an edge → latch A, B, CarryIN (and Sub) into shift registers.
  - Load the carry register with CarryIN, set step index to 0, go to RUN.
- RUN: each edge performs one step.
  - Feed the low nibbles of opA/opB plus the carry register to `four_bit_adder`.
  - Shift the adder's Sum into the result accumulator from the MSB end.
  - Store the adder's CarryOUT in the carry register.
  - Shift opA/opB right by 4 and increment the step index.
  - At the edge where the step index equals N-1, go to DONE and load Sum/CarryOUT from the final accumulator and carry.
- DONE: Done=1 for exactly one cycle; next edge → IDLE.
- Start during RUN or DONE is ignored; no queuing.
- Sum and CarryOUT change only on the transition into DONE and hold their values through IDLE until the next completion. No intermediate values are visible.
- Arithmetic: Sum = (A + B + CarryIN) mod 2^WIDTH; CarryOUT = bit WIDTH of the full sum.
- Wrap-around behaves as ordinary modular addition; there is no saturation.
- RESETn asserted mid-RUN: the operation is abandoned, all outputs return to 0 immediately, and no Done is emitted.

## Timing
- Start accepted at edge k.
- Done is high in the cycle following edge k+N (N cycles after acceptance). For WIDTH=16, Done follows edge k+4.
- Throughput: one operation per N+2 cycles; the earliest re-accept is at edge k+N+2.
- Busy rises after edge k and falls after edge k+N+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_SUB_EN defined:
  - Sub port present.
  - When the latched Sub=1, B is inverted per nibble and the initial carry is forced to 1; CarryIN is ignored.
  - Result is A - B mod 2^WIDTH; CarryOUT=1 means no borrow.
- SERIAL_SUB_EN undefined: no Sub port; addition only.

## Structure
- Shared package holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - nibble width constant NIB=4;
  - the WIDTH-multiple-of-4 rule, enforced as a static check in the top module.
- One sub-module, the existing `four_bit_adder`, instantiated once as the nibble datapath. The FSM, counters and shift registers live in serial_adder_controller.

## Test plan
- WIDTH=16, A=0x00FF, B=0x0001, CarryIN=0 → Sum=0x0100, CarryOUT=0; Done exactly 4 cycles after Start is accepted; Busy high for 5 cycles.
- A=0xFFFF, B=0x0000, CarryIN=1 → Sum=0x0000, CarryOUT=1, confirming the carry ripples across all 4 nibbles.
- Start pulsed again 2 cycles after acceptance with A=0x1111, B=0x1111 → ignored; first result 0x0100 is unchanged and only one Done pulse occurs.
- RESETn pulsed low during the 2nd RUN step → Sum=0, CarryOUT=0, Busy=0 immediately, no Done; a following Start of 0x1234+0x4321 → Sum=0x5555.
- SERIAL_SUB_EN, Sub=1, A=0x0005, B=0x0007 → Sum=0xFFFE, CarryOUT=0; A=0x0007, B=0x0005 → Sum=0x0002, CarryOUT=1.
- Back-to-back operations with Start held high continuously → accepted every 6 cycles; each Done carries the matching result; Sum holds its value between Dones.
